// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, sequencer state, destination select and decode record
package cpu_pkg;
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_TAX     = 8'hAA;
    localparam logic [7:0] OP_TXA     = 8'h8A;
    localparam logic [7:0] OP_INX     = 8'hE8;
    localparam logic [7:0] OP_DEX     = 8'hCA;
    localparam logic [7:0] OP_NOP     = 8'hEA;

    typedef enum logic [1:0] {FETCH_OP, FETCH_IMM, EXEC} seq_state_t;
    typedef enum logic [1:0] {DST_NONE, DST_A, DST_X} dst_t;

    // src_sel: 0 reads A, 1 reads X
    typedef struct packed {
        logic needs_imm;
        dst_t dst;
        logic src_sel;
        logic inc;
        logic dec;
        logic illegal;
    } op_dec_t;
endpackage

// File: rtl/cpu_op_decode.sv
// cpu_op_decode: combinational opcode decoder
//   opcode : instruction byte
//   op     : {needs_imm, dst, src_sel, inc, dec, illegal}
module cpu_op_decode
    import cpu_pkg::*;
(
    input  logic [7:0] opcode,
    output op_dec_t    op
);
    always_comb begin
        op = '0;
        case (opcode)
            OP_LDA_IMM: begin op.needs_imm = 1'b1; op.dst = DST_A; end
            OP_LDX_IMM: begin op.needs_imm = 1'b1; op.dst = DST_X; end
            OP_TAX:     op.dst = DST_X;
            OP_TXA:     begin op.dst = DST_A; op.src_sel = 1'b1; end
            OP_INX:     begin op.dst = DST_X; op.src_sel = 1'b1; op.inc = 1'b1; end
            OP_DEX:     begin op.dst = DST_X; op.src_sel = 1'b1; op.dec = 1'b1; end
            OP_NOP:     op.dst = DST_NONE;
            default:    op.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/cpu_rf_sequencer.sv
// cpu_rf_sequencer: decodes an opcode/operand byte stream into A/X register-file writes
//   clk_i, rst_i (sync, active-high)
//   instr_valid_i/instr_data_i/instr_ready_o : byte stream handshake
//   q_a_i, q_x_i                             : current register file contents
//   write_enable_{a,x}_o, data_{a,x}_o       : one-cycle write strobe and data
//   zero_o, negative_o                       : flags of the last written value
//   illegal_o                                : pulse after an unsupported opcode
module cpu_rf_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instr_valid_i,
    input  logic [DATA_W-1:0] instr_data_i,
    output logic              instr_ready_o,
    input  logic [DATA_W-1:0] q_a_i,
    input  logic [DATA_W-1:0] q_x_i,
    output logic              write_enable_a_o,
    output logic              write_enable_x_o,
    output logic [DATA_W-1:0] data_a_o,
    output logic [DATA_W-1:0] data_x_o,
    output logic              zero_o,
    output logic              negative_o,
    output logic              illegal_o
);
    seq_state_t        state, state_d;
    dst_t              dst_q, wr_dst;
    op_dec_t           op;
    logic              go_op, go_imm;
    logic [DATA_W-1:0] src, res, wr_data, last;

    cpu_op_decode u_dec (
        .opcode (instr_data_i),
        .op     (op)
    );

    assign instr_ready_o = (state == FETCH_OP) || (state == FETCH_IMM);

    // Results are computed in the accept cycle and registered straight into
    // the output strobe/data, so the EXEC cycle only presents them.
    always_comb begin
        go_op   = instr_valid_i && state == FETCH_OP;
        go_imm  = instr_valid_i && state == FETCH_IMM;
        src     = op.src_sel ? q_x_i : q_a_i;
        res     = op.inc ? src + DATA_W'(1) : op.dec ? src - DATA_W'(1) : src;
        wr_dst  = go_imm ? dst_q : (go_op && !op.needs_imm) ? op.dst : DST_NONE;
        wr_data = go_imm ? instr_data_i : res;
        last    = data_a_o | data_x_o;
        state_d = (state == EXEC) ? FETCH_OP :
                  (wr_dst != DST_NONE) ? EXEC :
                  (go_op && op.needs_imm) ? FETCH_IMM :
                  (state == FETCH_IMM) ? FETCH_IMM : FETCH_OP;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= FETCH_OP;
            dst_q            <= DST_NONE;
            write_enable_a_o <= 1'b0;
            write_enable_x_o <= 1'b0;
            data_a_o         <= '0;
            data_x_o         <= '0;
            zero_o           <= 1'b0;
            negative_o       <= 1'b0;
            illegal_o        <= 1'b0;
        end else begin
            state            <= state_d;
            if (go_op)
                dst_q <= op.dst;
            write_enable_a_o <= wr_dst == DST_A;
            write_enable_x_o <= wr_dst == DST_X;
            data_a_o         <= (wr_dst == DST_A) ? wr_data : '0;
            data_x_o         <= (wr_dst == DST_X) ? wr_data : '0;
            illegal_o        <= go_op && op.illegal;
            // only one data bus is non-zero during EXEC, so OR gives the written value
            if (state == EXEC) begin
                zero_o     <= last == '0;
                negative_o <= last[DATA_W-1];
            end
        end
    end
endmodule

// File: tb/tb_cpu_rf_sequencer.sv
// tb_cpu_rf_sequencer: directed and random-gap stimulus checked against a byte-stream interpreter model
module tb_cpu_rf_sequencer;
    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       instr_valid_i = 1'b0;
    logic [7:0] instr_data_i = 8'h00;
    logic       instr_ready_o;
    logic [7:0] q_a_i, q_x_i;
    logic       write_enable_a_o, write_enable_x_o;
    logic [7:0] data_a_o, data_x_o;
    logic       zero_o, negative_o, illegal_o;

    logic [7:0] ra = 8'h00, rx = 8'h00, ovr_v = 8'h00;
    logic       ovr_x = 1'b0;
    logic       chk_en = 1'b0;
    int         n_chk = 0, n_fail = 0;

    logic       exp_we_a = 0, exp_we_x = 0, exp_ill = 0, exp_z = 0, exp_n = 0, exp_rdy = 1;
    logic [7:0] exp_da = 0, exp_dx = 0, v;
    int         m_pend = 0;
    logic       acc;
    logic [7:0] ops [9];

    assign q_a_i = ra;
    assign q_x_i = ovr_x ? ovr_v : rx;

    cpu_rf_sequencer #(.DATA_W(8)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .instr_valid_i    (instr_valid_i),
        .instr_data_i     (instr_data_i),
        .instr_ready_o    (instr_ready_o),
        .q_a_i            (q_a_i),
        .q_x_i            (q_x_i),
        .write_enable_a_o (write_enable_a_o),
        .write_enable_x_o (write_enable_x_o),
        .data_a_o         (data_a_o),
        .data_x_o         (data_x_o),
        .zero_o           (zero_o),
        .negative_o       (negative_o),
        .illegal_o        (illegal_o)
    );

    always #5 clk = ~clk;

    // register file the sequencer writes into
    always @(posedge clk) begin
        if (rst_i) begin
            ra <= 8'h00;
            rx <= 8'h00;
        end else begin
            if (write_enable_a_o) ra <= data_a_o;
            if (write_enable_x_o) rx <= data_x_o;
        end
    end

    // Interpreter: every accepted byte is either an opcode or a pending operand;
    // a write shows up the cycle after acceptance, that cycle refuses input,
    // and flags follow one cycle after the write.
    always @(posedge clk) begin
        if (rst_i) begin
            exp_we_a = 0; exp_we_x = 0; exp_da = 0; exp_dx = 0;
            exp_ill = 0; exp_z = 0; exp_n = 0; exp_rdy = 1; m_pend = 0;
        end else begin
            if (exp_we_a || exp_we_x) begin
                v = exp_we_a ? exp_da : exp_dx;
                exp_z = (v == 8'h00);
                exp_n = v[7];
            end
            acc = instr_valid_i && exp_rdy;
            exp_we_a = 0; exp_we_x = 0; exp_da = 0; exp_dx = 0; exp_ill = 0;
            if (acc && m_pend == 1) begin exp_we_a = 1; exp_da = instr_data_i; m_pend = 0; end
            else if (acc && m_pend == 2) begin exp_we_x = 1; exp_dx = instr_data_i; m_pend = 0; end
            else if (acc) begin
                case (instr_data_i)
                    8'hA9: m_pend = 1;
                    8'hA2: m_pend = 2;
                    8'hAA: begin exp_we_x = 1; exp_dx = q_a_i; end
                    8'h8A: begin exp_we_a = 1; exp_da = q_x_i; end
                    8'hE8: begin exp_we_x = 1; exp_dx = q_x_i + 8'd1; end
                    8'hCA: begin exp_we_x = 1; exp_dx = q_x_i - 8'd1; end
                    8'hEA: ;
                    default: exp_ill = 1;
                endcase
            end
            exp_rdy = !(exp_we_a || exp_we_x);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_ready", 8'(instr_ready_o), 8'(exp_rdy));
            check("m_we_a", 8'(write_enable_a_o), 8'(exp_we_a));
            check("m_we_x", 8'(write_enable_x_o), 8'(exp_we_x));
            check("m_data_a", data_a_o, exp_da);
            check("m_data_x", data_x_o, exp_dx);
            check("m_illegal", 8'(illegal_o), 8'(exp_ill));
            check("m_zero", 8'(zero_o), 8'(exp_z));
            check("m_negative", 8'(negative_o), 8'(exp_n));
        end
    end

    // entered and left at a negedge; returns in the cycle after acceptance
    task automatic send(input logic [7:0] b);
        int t = 0;
        instr_valid_i = 1'b1;
        instr_data_i  = b;
        while (!instr_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t == 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: ready stuck low for byte %h", b);
        end
        @(negedge clk);
        instr_valid_i = 1'b0;
        instr_data_i  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ops = '{8'hA9, 8'hA2, 8'hAA, 8'h8A, 8'hE8, 8'hCA, 8'hEA, 8'h00, 8'hFF};
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_ready", 8'(instr_ready_o), 8'h01);
        check("rst_data_a", data_a_o, 8'h00);
        check("rst_flags", {6'b0, zero_o, negative_o}, 8'h00);

        send(8'hA9); send(8'h80);
        check("lda_we_a", 8'(write_enable_a_o), 8'h01);
        check("lda_data_a", data_a_o, 8'h80);
        check("lda_we_x", 8'(write_enable_x_o), 8'h00);
        idle(1);
        check("lda_strobe_gone", 8'(write_enable_a_o), 8'h00);
        check("lda_flags", {6'b0, zero_o, negative_o}, 8'h01);

        send(8'hA2); send(8'h00);
        check("ldx_data_x", data_x_o, 8'h00);
        check("ldx_ready_exec", 8'(instr_ready_o), 8'h00);
        send(8'h8A);
        check("txa_we_a", 8'(write_enable_a_o), 8'h01);
        check("txa_data_a", data_a_o, 8'h00);
        check("txa_zero_from_ldx", 8'(zero_o), 8'h01);
        check("txa_ready_exec", 8'(instr_ready_o), 8'h00);
        idle(1);

        ovr_x = 1'b1; ovr_v = 8'hFF;
        send(8'hE8);
        check("inx_wrap_data", data_x_o, 8'h00);
        idle(1);
        check("inx_wrap_flags", {6'b0, zero_o, negative_o}, 8'h02);
        ovr_v = 8'h00;
        send(8'hCA);
        check("dex_wrap_data", data_x_o, 8'hFF);
        idle(1);
        check("dex_wrap_flags", {6'b0, zero_o, negative_o}, 8'h01);
        ovr_x = 1'b0;

        send(8'hFF);
        check("ill_pulse", 8'(illegal_o), 8'h01);
        check("ill_no_strobe", {6'b0, write_enable_a_o, write_enable_x_o}, 8'h00);
        check("ill_flags_kept", {6'b0, zero_o, negative_o}, 8'h01);
        idle(1);
        check("ill_pulse_end", 8'(illegal_o), 8'h00);
        send(8'hEA);
        check("nop_no_pulse", 8'(illegal_o), 8'h00);
        check("nop_ready_next", 8'(instr_ready_o), 8'h01);

        send(8'hA2);
        idle(5);
        check("stall_no_strobe", 8'(write_enable_x_o), 8'h00);
        send(8'h3C);
        check("stall_data_x", data_x_o, 8'h3C);
        idle(1);

        send(8'hA9);
        instr_valid_i = 1'b1; instr_data_i = 8'h55; rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0; instr_valid_i = 1'b0;
        check("rimm_ready", 8'(instr_ready_o), 8'h01);
        idle(3);
        check("rimm_no_write", 8'(write_enable_a_o), 8'h00);

        send(8'hA2); send(8'h77);
        check("rexec_strobe", 8'(write_enable_x_o), 8'h01);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("rexec_we_x", 8'(write_enable_x_o), 8'h00);
        check("rexec_data_x", data_x_o, 8'h00);
        check("rexec_flags", {6'b0, zero_o, negative_o}, 8'h00);
        idle(2);

        for (int i = 0; i < 200; i++) begin
            logic [7:0] o;
            o = ops[$urandom_range(0, 8)];
            send(o);
            idle($urandom_range(0, 2));
            if (o == 8'hA9 || o == 8'hA2) begin
                send(8'($urandom));
                idle($urandom_range(0, 2));
            end
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_rf_sequencer.md
# cpu_rf_sequencer

Register-transfer sequencer that drives the write side of the CPU's A/X register file. It consumes an opcode/operand byte stream with a valid/ready handshake and decodes a small 6502-style instruction subset. For each instruction it issues exactly one single-cycle write strobe, with write data, to the A or X register, and it maintains Z/N flags. It sits between instruction fetch and the register file, and reads the register file's current A/X outputs back as operands.

## Interface

Parameters:
- `DATA_W`, default 8: register and byte width. Only 8 is supported.

Ports:
- `clk_i` input 1: single clock, rising edge.
- `rst_i` input 1: reset, **synchronous, active-high**.
- `instr_valid_i` input 1: an instruction-stream byte is present.
- `instr_data_i` input 8: opcode or immediate byte.
- `instr_ready_o` output 1: the sequencer accepts a byte this cycle.
- `q_a_i` input 8: current A value from the register file.
- `q_x_i` input 8: current X value from the register file.
- `write_enable_a_o` output 1: one-cycle write strobe for A.
- `write_enable_x_o` output 1: one-cycle write strobe for X.
- `data_a_o` output 8: write data for A.
- `data_x_o` output 8: write data for X.
- `zero_o` output 1: Z flag; set when the last written value was 0x00.
- `negative_o` output 1: N flag; equals bit 7 of the last written value.
- `illegal_o` output 1: one-cycle pulse when an unsupported opcode is accepted.

## Operation

Opcodes:
- 0xA9 LDA #imm: A ← imm.
- 0xA2 LDX #imm: X ← imm.
- 0xAA TAX: X ← A.
- 0x8A TXA: A ← X.
- 0xE8 INX: X ← X+1, mod 256.
- 0xCA DEX: X ← X−1, mod 256.
- 0xEA NOP: no write, flags unchanged.
- Any other opcode: no write, flags unchanged, `illegal_o` pulses, sequencer returns to FETCH_OP.

States:
- **FETCH_OP**
  - `instr_ready_o`=1.
  - On accept (`valid && ready`): immediate ops go to FETCH_IMM; TAX/TXA/INX/DEX go to EXEC; NOP and illegal opcodes stay in FETCH_OP.
- **FETCH_IMM**
  - `instr_ready_o`=1.
  - The operand is latched on accept, then the state goes to EXEC.
  - Waits indefinitely while `instr_valid_i`=0.
- **EXEC**
  - `instr_ready_o`=0.
  - The selected write enable is high for this one cycle only.
  - `data_*_o` hold the result.
  - Z/N update at the end of this cycle.
  - Next state is always FETCH_OP.

Rules:
- The result is computed from `q_a_i`/`q_x_i` sampled in the cycle the opcode is accepted. No write can be pending at that point, because EXEC always precedes FETCH_OP.
- At most one write enable is high in any cycle. Both are never high together.
- `data_a_o`/`data_x_o` are 0x00 whenever their enable is low.
- All outputs are registered, except `instr_ready_o`, which is decoded from state.
- Arithmetic wraps: INX on 0xFF gives 0x00 with Z=1, N=0. DEX on 0x00 gives 0xFF with Z=0, N=1.

## Timing

- Reset values:
  - state = FETCH_OP
  - `write_enable_a_o`=0, `write_enable_x_o`=0
  - `data_a_o`=0x00, `data_x_o`=0x00
  - `zero_o`=0, `negative_o`=0, `illegal_o`=0
  - `instr_ready_o`=1 from the first cycle after reset is released.
- Implied op (TAX/TXA/INX/DEX) accepted in cycle N:
  - write strobe in cycle N+1;
  - register file and flags show the new value in N+2;
  - next opcode can be accepted in N+2.
- Immediate op:
  - opcode accepted in N;
  - operand accepted in M ≥ N+1;
  - strobe in M+1;
  - next opcode in M+2.
- Throughput: one implied op per 2 cycles, one immediate op per 3 cycles minimum. NOP and illegal opcodes take 1 cycle.
- `illegal_o` is high in cycle N+1 for an illegal opcode accepted in cycle N.
- Reset asserted in any state, including FETCH_IMM with the operand pending or EXEC:
  - the next cycle is FETCH_OP with all outputs at reset values;
  - an aborted EXEC produces no strobe in the cycle after reset;
  - a latched operand is discarded.
- `instr_data_i` is ignored whenever `instr_valid_i`=0.

## Structure

- Shared package `cpu_pkg`:
  - opcode localparams: `OP_LDA_IMM`, `OP_LDX_IMM`, `OP_TAX`, `OP_TXA`, `OP_INX`, `OP_DEX`, `OP_NOP`;
  - state enum `seq_state_t` {FETCH_OP, FETCH_IMM, EXEC};
  - destination enum {DST_NONE, DST_A, DST_X}.
- One sub-module, `cpu_op_decode`, is combinational. It maps an opcode to `{needs_imm, dst, src_sel, inc, dec, illegal}`.
- The FSM, operand latch, result mux, incrementer/decrementer and flag registers live in the top module.

## Test plan

- **Reset and immediate load:** reset 2 cycles, then stream A9,80 → `write_enable_a_o`=1 with `data_a_o`=0x80 for exactly one cycle; afterwards Z=0, N=1, no X strobe.
- **Transfers:** LDX #00 then TXA, with `q_x_i` tied to 0x00 → X strobe data 0x00, Z=1, then A strobe data 0x00; `instr_ready_o` low exactly in each EXEC cycle.
- **Wrap:**
  - `q_x_i`=0xFF, INX → X strobe 0x00, Z=1, N=0.
  - `q_x_i`=0x00, DEX → X strobe 0xFF, Z=0, N=1.
- **Handshake stalls:**
  - A2 followed by 5 cycles of `instr_valid_i`=0, then 3C → no strobe during the stall; X strobe 0x3C one cycle after the operand is accepted.
  - Random valid gaps over 200 instructions, checked against a reference model.
- **Illegal opcode and NOP:**
  - 0xFF → one `illegal_o` pulse, no strobes, flags unchanged.
  - 0xEA → no pulse, no strobes; next opcode accepted the following cycle.
- **Reset mid-operation:**
  - reset asserted in FETCH_IMM after opcode A9 → the operand is never written;
  - reset asserted in the EXEC cycle → no strobe the next cycle; all outputs at reset values.
